// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs decoded control fields back into 9-bit machine code, the inverse of
//   the control decoder. Used by the program loader / self-test path to build
//   instruction-memory images. One registered valid/ready stage. A write-address
//   pointer tags every emitted word. Illegal field bundles are consumed and
//   counted, and no word is emitted for them.
//
// Optional feature (compile-time macro INSTR_ENC_RANGECHK_EN):
//   When the macro is defined, a bundle is also rejected in two cases:
//     - a field that would be truncated into a 2-bit slot holds a value above 3;
//     - the destination register Wd is inconsistent with the register the
//       encoding implies.
//   When the macro is undefined, fields are silently truncated and Wd is used
//   only by Ldr.
//
// Parameters
//   DEPTH  instruction-memory entries (address width AW = $clog2(DEPTH))
//   ERRW   width of the saturating error counter
//
// Ports
//   Clk        in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset
//   Start      in   synchronous restart; clears pointer, Full, Err, Err_cnt, pending word
//   In_valid   in   field bundle valid
//   In_ready   out  bundle accepted when In_valid & In_ready
//   Aluop      in   4-bit operation code (decoder encoding)
//   Ldr, Str   in   load / store flags
//   Ra, Rb     in   source registers (Rb is also the address register)
//   Wd         in   destination register
//   Imm        in   immediate / shift amount
//   Jptr       in   jump LUT index
//   Out_valid  out  Mach_code / Wr_addr valid
//   Out_ready  in   downstream accepts the word
//   Mach_code  out  encoded instruction
//   Wr_addr    out  instruction-memory address of Mach_code
//   Full       out  DEPTH words emitted since reset/Start
//   Err        out  sticky flag: at least one illegal bundle consumed
//   Err_cnt    out  saturating count of illegal bundles
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH = 32,
    parameter int ERRW  = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic            In_valid,
    output logic            In_ready,
    input  logic [3:0]      Aluop,
    input  logic            Ldr,
    input  logic            Str,
    input  logic [2:0]      Ra,
    input  logic [2:0]      Rb,
    input  logic [2:0]      Wd,
    input  logic [2:0]      Imm,
    input  logic [4:0]      Jptr,
    output logic            Out_valid,
    input  logic            Out_ready,
    output logic [8:0]      Mach_code,
    output logic [AW-1:0]   Wr_addr,
    output logic            Full,
    output logic            Err,
    output logic [ERRW-1:0] Err_cnt
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    logic            out_valid_q, out_valid_d;
    logic [8:0]      code_q, code_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            full_q, full_d;
    logic            err_q, err_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic [8:0]      enc_word;
    logic            base_illegal;
    logic            range_illegal;
    logic            bundle_illegal;
    logic            accept;

    // Field packing; bits [8:6] select the instruction class.
    always_comb begin
        enc_word = 9'd0;
        case (Aluop)
            4'b0000: begin
                if (Ldr)
                    enc_word = {3'b000, 1'b0, Wd, Rb[1:0]};
                else if (Str)
                    enc_word = {3'b000, 1'b1, Ra[1:0], Rb};
                else
                    enc_word = {3'b010, Aluop[1:0], Ra[1:0], Rb[1:0]};
            end
            4'b0001,
            4'b0010: enc_word = {3'b010, Aluop[1:0], Ra[1:0], Rb[1:0]};
            // Unary ops share the 010/11 prefix; the sub-op code is not Aluop order.
            4'b0011: enc_word = {3'b010, 2'b11, 2'b00, Ra[1:0]};
            4'b0100: enc_word = {3'b010, 2'b11, 2'b10, Ra[1:0]};
            4'b0101: enc_word = {3'b010, 2'b11, 2'b01, Ra[1:0]};
            4'b0110: enc_word = {3'b101, Ra, Rb};
            4'b0111: enc_word = {3'b110, Ra, Rb};
            4'b1000: enc_word = {3'b001, Ra, Rb};
            4'b1001: enc_word = {3'b011, Ra, Imm};
            4'b1010,
            4'b1011: enc_word = {3'b111, Aluop[0], Ra[1:0], Imm};
            4'b1100: enc_word = {3'b100, 1'b1, Jptr};
            4'b1101: enc_word = {3'b100, 1'b0, Jptr};
            default: enc_word = 9'd0;
        endcase
    end

    always_comb begin
        base_illegal = (Aluop >= 4'b1110) || (Ldr && Str) ||
                       ((Ldr || Str) && (Aluop != 4'b0000));
    end

`ifdef INSTR_ENC_RANGECHK_EN
    logic is_bin;
    logic is_unary;
    logic is_imm_alu;

    always_comb begin
        is_bin     = (Aluop <= 4'd2) && !Ldr && !Str;
        is_unary   = (Aluop >= 4'd3) && (Aluop <= 4'd5);
        is_imm_alu = (Aluop == 4'b1010) || (Aluop == 4'b1011);
        range_illegal =
            ((Ra > 3'd3) && (is_bin || is_unary || is_imm_alu || Str)) ||
            ((Rb > 3'd3) && (Ldr || is_bin)) ||
            ((Wd != Ra) && (is_bin || is_unary || is_imm_alu || (Aluop == 4'b1001))) ||
            ((Wd != Rb) && (Aluop == 4'b1000));
    end
`else
    assign range_illegal = 1'b0;
`endif

    assign bundle_illegal = base_illegal || range_illegal;

    // In_ready depends only on Start, Full and the output-stage state.
    assign In_ready = !Start && !full_q && (!out_valid_q || Out_ready);
    assign accept   = In_valid && In_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        code_d      = code_q;
        addr_d      = addr_q;
        ptr_d       = ptr_q;
        full_d      = full_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;

        if (Start) begin
            // A pending word is dropped; its data is left in place but never marked valid.
            out_valid_d = 1'b0;
            ptr_d       = '0;
            full_d      = 1'b0;
            err_d       = 1'b0;
            err_cnt_d   = '0;
        end else begin
            if (out_valid_q && Out_ready)
                out_valid_d = 1'b0;
            if (accept) begin
                if (bundle_illegal) begin
                    err_d     = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    out_valid_d = 1'b1;
                    code_d      = enc_word;
                    addr_d      = ptr_q;
                    if (ptr_q == LAST_PTR) begin
                        ptr_d  = '0;
                        full_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            addr_q      <= '0;
            ptr_q       <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            addr_q      <= addr_d;
            ptr_q       <= ptr_d;
            full_q      <= full_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign Out_valid = out_valid_q;
    assign Mach_code = code_q;
    assign Wr_addr   = addr_q;
    assign Full      = full_q;
    assign Err       = err_q;
    assign Err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 32;
    localparam int ERRW  = 8;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      aluop = '0;
    logic            ldr = 1'b0;
    logic            str = 1'b0;
    logic [2:0]      ra = '0;
    logic [2:0]      rb = '0;
    logic [2:0]      wd = '0;
    logic [2:0]      imm = '0;
    logic [4:0]      jptr = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [8:0]      mach_code;
    logic [AW-1:0]   wr_addr;
    logic            full;
    logic            err;
    logic [ERRW-1:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_ov, m_full, m_err;
    int m_code, m_addr, m_ptr, m_cnt;

    instr_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .Clk(clk), .Reset_n(rst_n), .Start(start),
        .In_valid(in_valid), .In_ready(in_ready),
        .Aluop(aluop), .Ldr(ldr), .Str(str),
        .Ra(ra), .Rb(rb), .Wd(wd), .Imm(imm), .Jptr(jptr),
        .Out_valid(out_valid), .Out_ready(out_ready),
        .Mach_code(mach_code), .Wr_addr(wr_addr),
        .Full(full), .Err(err), .Err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Instruction code from the field rules, built with plain arithmetic
    // (class * 64 + field weights).
    function automatic int ref_code(int op, int l, int s, int a, int b, int w, int im, int j);
        case (op)
            0: begin
                if (l != 0)      return w * 4 + (b % 4);
                else if (s != 0) return 32 + (a % 4) * 8 + b;
                else             return 128 + (a % 4) * 4 + (b % 4);
            end
            1, 2:  return 128 + op * 16 + (a % 4) * 4 + (b % 4);
            3:     return 128 + 48 + 0 + (a % 4);
            4:     return 128 + 48 + 8 + (a % 4);
            5:     return 128 + 48 + 4 + (a % 4);
            6:     return 5 * 64 + a * 8 + b;
            7:     return 6 * 64 + a * 8 + b;
            8:     return 1 * 64 + a * 8 + b;
            9:     return 3 * 64 + a * 8 + im;
            10, 11: return 7 * 64 + (op % 2) * 32 + (a % 4) * 8 + im;
            12:    return 4 * 64 + 32 + j;
            13:    return 4 * 64 + j;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_legal(int op, int l, int s, int a, int b, int w);
        if (op >= 14) return 1'b0;
        if (l != 0 && s != 0) return 1'b0;
        if ((l != 0 || s != 0) && op != 0) return 1'b0;
`ifdef INSTR_ENC_RANGECHK_EN
        begin
            bit bin, un, ad;
            bin = (op <= 2) && l == 0 && s == 0;
            un  = (op >= 3) && (op <= 5);
            ad  = (op == 10) || (op == 11);
            if (a > 3 && (bin || un || ad || s != 0)) return 1'b0;
            if (b > 3 && (l != 0 || bin)) return 1'b0;
            if (w != a && (bin || un || ad || op == 9)) return 1'b0;
            if (w != b && op == 8) return 1'b0;
        end
`endif
        return 1'b1;
    endfunction

    function automatic int cur_code();
        return ref_code(int'(aluop), int'(ldr), int'(str), int'(ra), int'(rb),
                        int'(wd), int'(imm), int'(jptr));
    endfunction

    function automatic bit cur_legal();
        return ref_legal(int'(aluop), int'(ldr), int'(str), int'(ra), int'(rb), int'(wd));
    endfunction

    task automatic model_reset();
        m_ov = 0; m_full = 0; m_err = 0;
        m_code = 0; m_addr = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Advance one clock and move the reference model along with it.
    task automatic tick();
        bit rdy, acc;
        rdy = !start && !m_full && (!m_ov || out_ready);
        acc = in_valid && rdy;
        @(posedge clk);
        if (start) begin
            m_ov = 0; m_ptr = 0; m_full = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (m_ov && out_ready) m_ov = 0;
            if (acc) begin
                if (!cur_legal()) begin
                    m_err = 1;
                    if (m_cnt < (1 << ERRW) - 1) m_cnt++;
                end else begin
                    m_code = cur_code();
                    m_addr = m_ptr;
                    m_ov   = 1;
                    if (m_ptr == DEPTH - 1) m_full = 1;
                    m_ptr  = (m_ptr + 1) % DEPTH;
                end
            end
        end
        #1;
    endtask

    task automatic set_bundle(int op, int l, int s, int a, int b, int w, int im, int j);
        aluop = 4'(op); ldr = 1'(l); str = 1'(s);
        ra = 3'(a); rb = 3'(b); wd = 3'(w); imm = 3'(im); jptr = 5'(j);
    endtask

    task automatic rand_bundle(bit legal_only);
        int mode;
        aluop = legal_only ? 4'($urandom_range(0, 13)) : 4'($urandom_range(0, 15));
        ldr = 1'b0; str = 1'b0;
        if (aluop == 4'd0) begin
            mode = int'($urandom_range(0, 2));
            ldr = (mode == 1); str = (mode == 2);
        end
        if (!legal_only && $urandom_range(0, 7) == 0) begin
            ldr = 1'($urandom_range(0, 1)); str = 1'($urandom_range(0, 1));
        end
        ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
        wd = 3'($urandom_range(0, 7)); imm = 3'($urandom_range(0, 7));
        jptr = 5'($urandom_range(0, 31));
`ifdef INSTR_ENC_RANGECHK_EN
        if (legal_only) begin
            ra = ra & 3'd3; rb = rb & 3'd3;
            wd = (aluop == 4'd8) ? rb : ra;
        end
`endif
    endtask

    task automatic do_reset();
        in_valid = 0; start = 0; out_ready = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; start = 0; out_ready = 1; rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, mach_code, wr_addr, full, err, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got ov=%b code=%h addr=%0d full=%b err=%b cnt=%0d expected all zero",
                     out_valid, mach_code, wr_addr, full, err, err_cnt);
        end
        model_reset();
        rst_n = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        // Shift Ra=3 Imm=6 -> 0x0DE, then hold it under backpressure and reset mid-transfer.
        set_bundle(9, 0, 0, 3, 0, 3, 6, 0);
        in_valid = 1;
        tick();
        in_valid = 0; out_ready = 0;
        #1;
        n_tests++;
        if ({out_valid, mach_code} !== {1'b1, 9'h0DE}) begin
            n_fail++;
            $display("FAIL pre_async_reset: got ov=%b code=%h expected ov=1 code=0de", out_valid, mach_code);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({out_valid, mach_code, wr_addr, full, err, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ov=%b code=%h addr=%0d expected zero without clock edge",
                     out_valid, mach_code, wr_addr);
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1; out_ready = 1;
        #1;
    endtask

    int v_op[7]   = '{0, 0, 5, 12, 13, 2, 11};
    int v_l[7]    = '{1, 0, 0, 0, 0, 0, 0};
    int v_s[7]    = '{0, 1, 0, 0, 0, 0, 0};
    int v_a[7]    = '{0, 1, 2, 0, 0, 1, 3};
    int v_b[7]    = '{3, 5, 0, 0, 0, 3, 0};
    int v_w[7]    = '{6, 0, 2, 0, 0, 1, 3};
    int v_im[7]   = '{0, 0, 0, 0, 0, 0, 7};
    int v_j[7]    = '{0, 0, 0, 17, 3, 0, 0};
    int v_code[7] = '{'h01B, 'h02D, 'h0B6, 'h131, 'h103, 'h0A7, 'h1FF};

    task automatic test_encodings();
        do_reset();
        set_bundle(10, 0, 0, 2, 0, 2, 5, 0);
        in_valid = 1;
        tick();
        in_valid = 0;
        n_tests++;
        if ({out_valid, mach_code, wr_addr} !== {1'b1, 9'h1D5, 5'd0}) begin
            n_fail++;
            $display("FAIL addi_first: got ov=%b code=%h addr=%0d expected ov=1 code=1d5 addr=0",
                     out_valid, mach_code, wr_addr);
        end
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_bundle(v_op[i], v_l[i], v_s[i], v_a[i], v_b[i], v_w[i], v_im[i], v_j[i]);
            in_valid = 1;
            tick();
            n_tests++;
            if ({out_valid, mach_code, wr_addr} !== {1'b1, 9'(v_code[i]), AW'(i)}) begin
                n_fail++;
                $display("FAIL encode_vec%0d: got ov=%b code=%h addr=%0d expected ov=1 code=%h addr=%0d",
                         i, out_valid, mach_code, wr_addr, v_code[i], i);
            end
        end
        in_valid = 0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_after_vectors: got ov=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_bundle(8, 0, 0, 3, 4, 4, 0, 0);      // mov -> 0x05C
        in_valid = 1;
        tick();
        set_bundle(7, 0, 0, 1, 2, 0, 0, 0);      // beq -> 0x18A
        out_ready = 0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if ({in_ready, out_valid, mach_code, wr_addr} !== {1'b0, 1'b1, 9'h05C, 5'd0}) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got rdy=%b ov=%b code=%h addr=%0d expected rdy=0 ov=1 code=05c addr=0",
                         k, in_ready, out_valid, mach_code, wr_addr);
            end
            tick();
        end
        out_ready = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b expected 1", in_ready);
        end
        tick();
        n_tests++;
        if ({out_valid, mach_code, wr_addr} !== {1'b1, 9'h18A, 5'd1}) begin
            n_fail++;
            $display("FAIL release_word1: got ov=%b code=%h addr=%0d expected ov=1 code=18a addr=1",
                     out_valid, mach_code, wr_addr);
        end
        set_bundle(9, 0, 0, 7, 0, 7, 2, 0);      // shift -> 0x0FA
        tick();
        n_tests++;
        if ({out_valid, mach_code, wr_addr} !== {1'b1, 9'h0FA, 5'd2}) begin
            n_fail++;
            $display("FAIL release_word2: got ov=%b code=%h addr=%0d expected ov=1 code=0fa addr=2",
                     out_valid, mach_code, wr_addr);
        end
        in_valid = 0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_drain: got ov=%b expected 0", out_valid);
        end
    endtask

    task automatic test_full();
        int exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            rand_bundle(1'b1);
            exp = cur_code();
            in_valid = 1;
            tick();
            n_tests++;
            if ({out_valid, mach_code, wr_addr} !== {1'b1, 9'(exp), AW'(i)}) begin
                n_fail++;
                $display("FAIL stream_word%0d: got ov=%b code=%h addr=%0d expected ov=1 code=%h addr=%0d",
                         i, out_valid, mach_code, wr_addr, exp, i);
            end
            if (i == DEPTH - 2) begin
                n_tests++;
                if (full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early: got %b expected 0 after %0d words", full, i + 1);
                end
            end
        end
        rand_bundle(1'b1);
        #1;
        n_tests++;
        if ({full, wr_addr, in_ready} !== {1'b1, 5'd31, 1'b0}) begin
            n_fail++;
            $display("FAIL full_set: got full=%b addr=%0d rdy=%b expected full=1 addr=31 rdy=0",
                     full, wr_addr, in_ready);
        end
        tick();
        n_tests++;
        if ({out_valid, full} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_drain: got ov=%b full=%b expected ov=0 full=1", out_valid, full);
        end
        start = 1;
        tick();
        start = 0;
        n_tests++;
        if ({full, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_clear: got full=%b ov=%b expected 0 0", full, out_valid);
        end
        set_bundle(10, 0, 0, 2, 0, 2, 5, 0);
        tick();
        in_valid = 0;
        n_tests++;
        if ({out_valid, mach_code, wr_addr} !== {1'b1, 9'h1D5, 5'd0}) begin
            n_fail++;
            $display("FAIL after_start: got ov=%b code=%h addr=%0d expected ov=1 code=1d5 addr=0",
                     out_valid, mach_code, wr_addr);
        end
        tick();
    endtask

    task automatic test_errors();
        int e;
        do_reset();
        set_bundle(15, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1;
        tick();
        n_tests++;
        if ({err, err_cnt, out_valid} !== {1'b1, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_op: got err=%b cnt=%0d ov=%b expected err=1 cnt=1 ov=0",
                     err, err_cnt, out_valid);
        end
        set_bundle(0, 0, 0, 5, 1, 5, 0, 0);
        tick();
`ifdef INSTR_ENC_RANGECHK_EN
        e = 2;
        n_tests++;
        if ({err_cnt, out_valid} !== {8'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL range_reject: got cnt=%0d ov=%b expected cnt=2 ov=0", err_cnt, out_valid);
        end
`else
        e = 1;
        n_tests++;
        if ({out_valid, mach_code, wr_addr, err_cnt} !== {1'b1, 9'h085, 5'd0, 8'd1}) begin
            n_fail++;
            $display("FAIL truncate_add: got ov=%b code=%h addr=%0d cnt=%0d expected ov=1 code=085 addr=0 cnt=1",
                     out_valid, mach_code, wr_addr, err_cnt);
        end
`endif
        set_bundle(0, 1, 1, 0, 0, 0, 0, 0);      // Ldr & Str
        tick();
        set_bundle(3, 0, 1, 0, 0, 0, 0, 0);      // Str with non-zero Aluop
        tick();
        n_tests++;
        if ({err, err_cnt} !== {1'b1, 8'(e + 2)}) begin
            n_fail++;
            $display("FAIL ldr_str_reject: got err=%b cnt=%0d expected err=1 cnt=%0d", err, err_cnt, e + 2);
        end
        set_bundle(14, 0, 0, 0, 0, 0, 0, 0);
        for (int k = e + 2; k < 256; k++) tick();
        n_tests++;
        if (err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_saturate: got %0d expected 255", err_cnt);
        end
        tick();
        n_tests++;
        if (err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_hold_sat: got %0d expected 255", err_cnt);
        end
        in_valid = 0;
        start = 1;
        tick();
        start = 0;
        n_tests++;
        if ({err, err_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL err_start_clear: got err=%b cnt=%0d expected 0 0", err, err_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            start     = ($urandom_range(0, 149) == 0);
            rand_bundle(1'b0);
            #1;
            n_tests++;
            if (in_ready !== (!start && !m_full && (!m_ov || out_ready))) begin
                n_fail++;
                $display("FAIL rand_ready c%0d: got %b expected %b", c, in_ready,
                         (!start && !m_full && (!m_ov || out_ready)));
            end
            tick();
            n_tests++;
            if ({out_valid, full, err, err_cnt} !== {m_ov, m_full, m_err, 8'(m_cnt)}) begin
                n_fail++;
                $display("FAIL rand_state c%0d: got ov=%b full=%b err=%b cnt=%0d expected ov=%b full=%b err=%b cnt=%0d",
                         c, out_valid, full, err, err_cnt, m_ov, m_full, m_err, m_cnt);
            end
            if (m_ov) begin
                n_tests++;
                if ({mach_code, wr_addr} !== {9'(m_code), AW'(m_addr)}) begin
                    n_fail++;
                    $display("FAIL rand_word c%0d: got code=%h addr=%0d expected code=%h addr=%0d",
                             c, mach_code, wr_addr, m_code, m_addr);
                end
            end
        end
        in_valid = 0; start = 0; out_ready = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_backpressure();
        test_full();
        test_errors();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
